sram_dp_param: RTL and testbench

Parametrised single-clock dual-port SRAM; the next-generation replacement for the fixed 8-bit × 64K image buffer used by the convolution datapath. Each of the two ports can read or write on every cycle. The block adds:
- configurable data/address width;
- selectable read-during-write mode and optional output pipeline register;
- read-valid strobes and address-collision reporting;
- an optional hardware clear engine that sweeps the array to a constant.

---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_dp_outpipe.sv | 63 ++++++
 rtl/sram_dp_param.sv | 136 +++++++++++++
 tb/tb_sram_dp_param.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the parametrised dual-port SRAM: read-during-write
// encodings, clear-engine state type and the default word width.
package sram_pkg;

    localparam int DEF_DATA_W = 8;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/sram_dp_outpipe.sv
// Per-port output stage: registers read data, valid and collision flag,
// with an optional second register stage selected by OUT_REG.
module sram_dp_outpipe #(
    parameter int DATA_W  = 8,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    input  logic              hit,
    output logic [DATA_W-1:0] q,
    output logic              vld,
    output logic              coll
);

    logic [DATA_W-1:0] q_p0;
    logic              vld_p0;
    logic              coll_p0;

    // Stage 0: capture array read; data holds while the port is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            q_p0    <= '0;
            vld_p0  <= 1'b0;
            coll_p0 <= 1'b0;
        end else begin
            vld_p0  <= en;
            coll_p0 <= en & hit;
            if (en) q_p0 <= d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_p1
            logic [DATA_W-1:0] q_p1;
            logic              vld_p1;
            logic              coll_p1;

            // Stage 1: plain retiming copy of stage 0
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_p1    <= '0;
                    vld_p1  <= 1'b0;
                    coll_p1 <= 1'b0;
                end else begin
                    q_p1    <= q_p0;
                    vld_p1  <= vld_p0;
                    coll_p1 <= coll_p0;
                end
            end

            assign q    = q_p1;
            assign vld  = vld_p1;
            assign coll = coll_p1;
        end else begin : g_p0
            assign q    = q_p0;
            assign vld  = vld_p0;
            assign coll = coll_p0;
        end
    endgenerate

endmodule

// File: rtl/sram_dp_param.sv
// Parametrised single-clock dual-port SRAM with collision reporting.
// Optional clear engine compiled in when SRAM_DP_CLEAR_EN is defined.
module sram_dp_param
    import sram_pkg::*;
#(
    parameter int                 DATA_W    = DEF_DATA_W,
    parameter int                 ADDR_W    = 16,
    parameter int                 RD_MODE   = RD_FIRST,
    parameter int                 OUT_REG   = 0,
    parameter string              INIT_FILE = "",
    parameter logic [DATA_W-1:0]  CLR_VAL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              enb,
    input  logic              wena,
    input  logic              wenb,
    input  logic [ADDR_W-1:0] addra,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] da,
    input  logic [DATA_W-1:0] db,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    output logic              qa_vld,
    output logic              qb_vld,
    output logic              coll,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              blk;
    logic              sw_we;
    logic [ADDR_W-1:0] cnt;
    logic              acc_a, acc_b, wr_a, wr_b_req, wr_b, same, hit;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              unused_coll_b;

    assign acc_a    = ena & ~blk;
    assign acc_b    = enb & ~blk;
    assign wr_a     = acc_a & ~wena;
    assign wr_b_req = acc_b & ~wenb;
    assign same     = (addra == addrb);
    // Port A wins a same-address double write; B's write is dropped
    assign wr_b     = wr_b_req & ~(wr_a & same);
    assign hit      = acc_a & acc_b & same & (wr_a | wr_b_req);

    assign rd_a = (RD_MODE == WR_FIRST && wr_a)     ? da : mem[addra];
    assign rd_b = (RD_MODE == WR_FIRST && wr_b_req) ? db : mem[addrb];

    always_ff @(posedge clk) begin
        if (sw_we) begin
            mem[cnt] <= CLR_VAL;
        end else begin
            if (wr_a) mem[addra] <= da;
            if (wr_b) mem[addrb] <= db;
        end
    end

`ifdef SRAM_DP_CLEAR_EN
    clr_state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLR_IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    if (clr_req) begin
                        state    <= CLR_SWEEP;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLR_SWEEP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state    <= CLR_DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                CLR_DONE: begin
                    state    <= CLR_IDLE;
                    clr_done <= 1'b0;
                end
                default: state <= CLR_IDLE;
            endcase
        end
    end

    assign blk = (state == CLR_SWEEP);
    // A reset landing mid-sweep must not write the current address
    assign sw_we = blk & ~rst;
`else
    logic unused_clr;

    assign unused_clr = clr_req;
    assign cnt        = '0;
    assign blk        = 1'b0;
    assign sw_we      = 1'b0;
    assign clr_busy   = 1'b0;
    assign clr_done   = 1'b0;
`endif

    sram_dp_outpipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_a (
        .clk  (clk),
        .rst  (rst),
        .en   (acc_a),
        .d    (rd_a),
        .hit  (hit),
        .q    (qa),
        .vld  (qa_vld),
        .coll (coll)
    );

    sram_dp_outpipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_b (
        .clk  (clk),
        .rst  (rst),
        .en   (acc_b),
        .d    (rd_b),
        .hit  (hit),
        .q    (qb),
        .vld  (qb_vld),
        .coll (unused_coll_b)
    );

endmodule

// File: tb/tb_sram_dp_param.sv
// Scoreboard bench for sram_dp_param: one read-first/1-cycle instance and one
// write-first/2-cycle instance share stimulus; SRAM_DP_CLEAR_EN selects clear tests.
module tb_sram_dp_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena, enb, wena, wenb, clr_req;
    logic [3:0] addra, addrb;
    logic [7:0] da, db;

    logic [7:0] qa0, qb0, qa1, qb1;
    logic       qav0, qbv0, qav1, qbv1, coll0, coll1;
    logic       busy0, busy1, done0, done1;

    always #5 clk = ~clk;

    sram_dp_param #(.DATA_W(8), .ADDR_W(4), .RD_MODE(0), .OUT_REG(0),
                    .INIT_FILE(""), .CLR_VAL(8'hFF)) u0 (
        .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wena(wena), .wenb(wenb),
        .addra(addra), .addrb(addrb), .da(da), .db(db), .qa(qa0), .qb(qb0),
        .qa_vld(qav0), .qb_vld(qbv0), .coll(coll0), .clr_req(clr_req),
        .clr_busy(busy0), .clr_done(done0));

    sram_dp_param #(.DATA_W(8), .ADDR_W(4), .RD_MODE(1), .OUT_REG(1),
                    .INIT_FILE(""), .CLR_VAL(8'hFF)) u1 (
        .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wena(wena), .wenb(wenb),
        .addra(addra), .addrb(addrb), .da(da), .db(db), .qa(qa1), .qb(qb1),
        .qa_vld(qav1), .qb_vld(qbv1), .coll(coll1), .clr_req(clr_req),
        .clr_busy(busy1), .clr_done(done1));

    typedef struct {
        int       due;
        logic [7:0] d;
        bit       c;
        bit       chk;
    } exp_t;

    // Streams: 0 = u0 port A, 1 = u0 port B, 2 = u1 port A, 3 = u1 port B
    exp_t       sbq [4][$];
    logic [7:0] mdl [16];
    logic [7:0] last_q [4];
    bit         known [4];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         busy_n [2] = '{0, 0};
    int         done_n [2] = '{0, 0};
    bit         blocked = 0;
    bit         no_data = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, want, cyc);
    endtask

    task automatic push(input int s, input int due, input logic [7:0] d, input bit c);
        exp_t e;
        e.due = due; e.d = d; e.c = c; e.chk = !no_data;
        sbq[s].push_back(e);
    endtask

    // One access cycle on both ports; wa/wb = 1 means write (wen driven low)
    task automatic acc(input bit ea, input bit wa, input int aa, input logic [7:0] dva,
                       input bit eb, input bit wb, input int ab, input logic [7:0] dvb);
        logic [7:0] oa, ob;
        bit c;
        ena = ea; wena = ~wa; addra = aa[3:0]; da = dva;
        enb = eb; wenb = ~wb; addrb = ab[3:0]; db = dvb;
        if (!blocked) begin
            oa = mdl[aa];
            ob = mdl[ab];
            c  = ea && eb && (aa == ab) && (wa || wb);
            if (ea) begin
                push(0, cyc + 1, oa, c);
                push(2, cyc + 2, wa ? dva : oa, c);
            end
            if (eb) begin
                push(1, cyc + 1, ob, c);
                push(3, cyc + 2, wb ? dvb : ob, c);
            end
            if (eb && wb) mdl[ab] = dvb;
            if (ea && wa) mdl[aa] = dva;
        end
        @(posedge clk); #1;
        ena = 1'b0; enb = 1'b0; wena = 1'b1; wenb = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy0) busy_n[0] <= busy_n[0] + 1;
        if (busy1) busy_n[1] <= busy_n[1] + 1;
        if (done0) done_n[0] <= done_n[0] + 1;
        if (done1) done_n[1] <= done_n[1] + 1;
    end

    always @(negedge clk) begin : mon
        logic [7:0] qv [4];
        bit         vv [4];
        bit         cv [4];
        exp_t       e;
        qv = '{qa0, qb0, qa1, qb1};
        vv = '{qav0, qbv0, qav1, qbv1};
        cv = '{coll0, coll0, coll1, coll1};
        for (int s = 0; s < 4; s++) begin
            if (rst) begin
                last_q[s] <= 8'h00;
                known[s]  <= 1'b1;
            end else if (sbq[s].size() > 0 && sbq[s][0].due == cyc) begin
                e = sbq[s].pop_front();
                check($sformatf("vld s%0d", s), vv[s], 1);
                if (e.chk) check($sformatf("q s%0d", s), qv[s], e.d);
                check($sformatf("coll s%0d", s), cv[s], e.c);
                last_q[s] <= e.d;
                known[s]  <= e.chk;
            end else begin
                check($sformatf("idle_vld s%0d", s), vv[s], 0);
                if (known[s]) check($sformatf("hold_q s%0d", s), qv[s], last_q[s]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0, b1, d0, d1;
        rst = 1'b1; clr_req = 1'b0;
        ena = 1'b0; enb = 1'b0; wena = 1'b1; wenb = 1'b1;
        addra = '0; addrb = '0; da = '0; db = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst qa0", qa0, 0);   check("rst qb0", qb0, 0);
        check("rst qa1", qa1, 0);   check("rst qb1", qb1, 0);
        check("rst vld0", {qav0, qbv0}, 0);
        check("rst vld1", {qav1, qbv1}, 0);
        check("rst coll", {coll0, coll1}, 0);
        check("rst clr", {busy0, done0, busy1, done1}, 0);
        rst = 1'b0;

        no_data = 1;
        for (int i = 0; i < 16; i++) acc(1, 1, i, 8'h40 + i[7:0], 0, 0, 0, 8'h00);
        no_data = 0;

        // write then read on the other port
        acc(1, 1, 3, 8'h5A, 0, 0, 0, 8'h00);
        acc(0, 0, 0, 8'h00, 1, 0, 3, 8'h00);
        // A writes while B reads same address: old data, coll
        acc(1, 1, 7, 8'h11, 0, 0, 0, 8'h00);
        acc(1, 1, 7, 8'h22, 1, 0, 7, 8'h00);
        acc(0, 0, 0, 8'h00, 1, 0, 7, 8'h00);
        // both write same address: A wins
        acc(1, 1, 2, 8'hAA, 1, 1, 2, 8'hBB);
        acc(1, 0, 2, 8'h00, 1, 0, 2, 8'h00);
        // same-port read during write
        acc(1, 1, 5, 8'h3C, 0, 0, 0, 8'h00);
        acc(1, 0, 5, 8'h00, 0, 0, 0, 8'h00);
        // back-to-back reads
        acc(1, 0, 0, 8'h00, 1, 0, 8, 8'h00);
        acc(1, 0, 1, 8'h00, 1, 0, 9, 8'h00);
        acc(1, 0, 2, 8'h00, 1, 0, 10, 8'h00);
        idle(3);
        // disabled port with wen low must not write
        acc(0, 1, 4, 8'hEE, 0, 1, 6, 8'hDD);
        acc(1, 0, 4, 8'h00, 1, 0, 6, 8'h00);
        idle(2);

`ifdef SRAM_DP_CLEAR_EN
        b0 = busy_n[0]; b1 = busy_n[1]; d0 = done_n[0]; d1 = done_n[1];
        clr_req = 1'b1;
        acc(1, 1, 9, 8'h77, 0, 0, 0, 8'h00);
        clr_req = 1'b0;
        blocked = 1;
        acc(1, 1, 9, 8'h99, 1, 0, 4, 8'h00);
        blocked = 0;
        idle(20);
        check("busy_len u0", busy_n[0] - b0, 16);
        check("busy_len u1", busy_n[1] - b1, 16);
        check("done_cnt u0", done_n[0] - d0, 1);
        check("done_cnt u1", done_n[1] - d1, 1);
        for (int i = 0; i < 16; i++) mdl[i] = 8'hFF;
        for (int i = 0; i < 16; i++) acc(1, 0, i, 8'h00, 1, 0, 15 - i, 8'h00);

        for (int i = 0; i < 16; i++) acc(1, 1, i, 8'h60 + i[7:0], 0, 0, 0, 8'h00);
        idle(2);
        b0 = busy_n[0]; d0 = done_n[0]; d1 = done_n[1];
        clr_req = 1'b1;
        idle(1);
        clr_req = 1'b0;
        idle(5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("abort busy u0", busy0, 0);
        check("abort busy u1", busy1, 0);
        idle(20);
        check("abort busy_len", busy_n[0] - b0, 6);
        check("abort done u0", done_n[0] - d0, 0);
        check("abort done u1", done_n[1] - d1, 0);
        for (int i = 0; i < 5; i++) mdl[i] = 8'hFF;
        for (int i = 0; i < 16; i++) acc(1, 0, i, 8'h00, 1, 0, 15 - i, 8'h00);
`else
        b0 = busy_n[0]; b1 = busy_n[1]; d0 = done_n[0]; d1 = done_n[1];
        clr_req = 1'b1;
        idle(1);
        clr_req = 1'b0;
        idle(20);
        check("noclr busy u0", busy_n[0] - b0, 0);
        check("noclr busy u1", busy_n[1] - b1, 0);
        check("noclr done u0", done_n[0] - d0, 0);
        check("noclr done u1", done_n[1] - d1, 0);
        for (int i = 0; i < 16; i++) acc(1, 0, i, 8'h00, 1, 0, 15 - i, 8'h00);
`endif

        idle(6);
        for (int s = 0; s < 4; s++) check($sformatf("drain s%0d", s), sbq[s].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
